// File: rtl/lcd_pkg.sv
// Shared definitions for the parametrised RGB565 LCD timing controller:
// mode encoding, RGB565 colour constants, bar table and default 480x272 timing.
package lcd_pkg;

  typedef enum logic [1:0] {
    MODE_EXT   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHK   = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  localparam int DEF_H_ACT  = 480;
  localparam int DEF_H_FP   = 2;
  localparam int DEF_H_SYNC = 1;
  localparam int DEF_H_BP   = 43;
  localparam int DEF_V_ACT  = 272;
  localparam int DEF_V_FP   = 1;
  localparam int DEF_V_SYNC = 1;
  localparam int DEF_V_BP   = 12;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// Generic display-axis counter: active / front porch / sync / back porch,
// with combinational active and sync flags and a wrap strobe.
module lcd_axis_cnt
  import lcd_pkg::*;
#(
  parameter int ACT  = DEF_H_ACT,
  parameter int FP   = DEF_H_FP,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BP   = DEF_H_BP,
  parameter int CW   = 16
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          active,
  output logic          sync,
  output logic          wrap
);

  localparam int TOTAL  = ACT + FP + SYNC + BP;
  localparam int SYNC_S = ACT + FP;
  localparam int SYNC_E = ACT + FP + SYNC;

  always_ff @(posedge pclk) begin
    if (rst)       cnt <= '0;
    else if (en)   cnt <= wrap ? '0 : cnt + 1'b1;
  end

  always_comb begin
    active = (cnt < CW'(ACT));
    sync   = (cnt >= CW'(SYNC_S)) && (cnt < CW'(SYNC_E));
    wrap   = en && (cnt == CW'(TOTAL - 1));
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB565 parallel-LCD timing controller with test patterns and a pixel-fetch
// port whose return latency is PIX_LAT; all LCD pins leave one aligned register.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_ACT    = DEF_H_ACT,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 2,
  parameter int CHK_LOG2 = 5,
  parameter int CW       = 16
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [15:0]   solid_rgb,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  input  logic [15:0]   pixel_in,
  output logic          frame_start,
  output logic          LCD_DE,
  output logic          LCD_HSYNC,
  output logic          LCD_VSYNC,
  output logic [4:0]    LCD_R,
  output logic [5:0]    LCD_G,
  output logic [4:0]    LCD_B
);

  localparam int BAR_W = H_ACT >> 3;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic ext;
  } ctl_t;

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_act, h_sync, h_wrap;
  logic          v_act, v_sync, v_wrap;

  lcd_axis_cnt #(.ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)) u_h_cnt (
    .pclk(pclk), .rst(rst), .en(1'b1),
    .cnt(h_cnt), .active(h_act), .sync(h_sync), .wrap(h_wrap)
  );

  lcd_axis_cnt #(.ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)) u_v_cnt (
    .pclk(pclk), .rst(rst), .en(h_wrap),
    .cnt(v_cnt), .active(v_act), .sync(v_sync), .wrap(v_wrap)
  );

  // High exactly while the counters sit at (0,0): after reset or a full-frame wrap.
  logic at_origin;
  always_ff @(posedge pclk) begin
    if (rst) at_origin <= 1'b1;
    else     at_origin <= h_wrap & v_wrap;
  end

  mode_e       mode_lat, mode_cur;
  logic [15:0] solid_lat, solid_cur;

  always_ff @(posedge pclk) begin
    if (rst)            mode_lat <= MODE_BARS;
    else if (at_origin) mode_lat <= mode_e'(mode);
  end

  always_ff @(posedge pclk) begin
    if (at_origin) solid_lat <= solid_rgb;
  end

  // The origin pixel itself must already use the freshly sampled settings.
  always_comb begin
    mode_cur  = at_origin ? mode_e'(mode) : mode_lat;
    solid_cur = at_origin ? solid_rgb     : solid_lat;
  end

  logic [CW-1:0] bar_px;
  logic [2:0]    bar_idx;
  always_ff @(posedge pclk) begin
    if (rst || h_wrap) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (h_act && bar_idx != 3'd7) begin
      if (bar_px == CW'(BAR_W - 1)) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px  <= bar_px + 1'b1;
      end
    end
  end

  logic [15:0] gen_rgb;
  always_comb begin
    gen_rgb = RGB_BLACK;
    unique case (mode_cur)
      MODE_BARS:  gen_rgb = bar_colour(bar_idx);
      MODE_CHK:   gen_rgb = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? RGB_BLACK : RGB_WHITE;
      MODE_SOLID: gen_rgb = solid_cur;
      default:    gen_rgb = RGB_BLACK;
    endcase
  end

  ctl_t        ctl_p [0:PIX_LAT];
  logic [15:0] rgb_p [0:PIX_LAT];

  // p0: request stage, then PIX_LAT-deep chain matching the source return latency
  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_start <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      for (int i = 0; i <= PIX_LAT; i++) ctl_p[i] <= '0;
    end else begin
      frame_start <= at_origin;
      req_x       <= h_cnt;
      req_y       <= v_cnt;
      ctl_p[0]    <= ctl_t'{h_act & v_act, h_sync, v_sync, mode_cur == MODE_EXT};
      for (int i = 1; i <= PIX_LAT; i++) ctl_p[i] <= ctl_p[i-1];
    end
  end

  always_ff @(posedge pclk) begin
    rgb_p[0] <= gen_rgb;
    for (int i = 1; i <= PIX_LAT; i++) rgb_p[i] <= rgb_p[i-1];
  end

  assign req = ctl_p[0].de;

  logic [15:0] pix_sel;
  always_comb begin
    pix_sel = 16'h0000;
    if (ctl_p[PIX_LAT].de) pix_sel = ctl_p[PIX_LAT].ext ? pixel_in : rgb_p[PIX_LAT];
  end

  // pin stage: one register for every LCD pin
  always_ff @(posedge pclk) begin
    if (rst) begin
      LCD_DE                  <= 1'b0;
      LCD_HSYNC               <= ~HS_POL;
      LCD_VSYNC               <= ~VS_POL;
      {LCD_R, LCD_G, LCD_B}   <= 16'h0000;
    end else begin
      LCD_DE                  <= ctl_p[PIX_LAT].de;
      LCD_HSYNC               <= ctl_p[PIX_LAT].hs ^ ~HS_POL;
      LCD_VSYNC               <= ctl_p[PIX_LAT].vs ^ ~VS_POL;
      {LCD_R, LCD_G, LCD_B}   <= pix_sel;
    end
  end

endmodule
